// File: rtl/uart_tx_oversampled.sv
// UART transmitter timed from the shared oversampled RX clock: start bit, LSB-first data,
// optional parity, one stop bit. Each bit lasts max(prescale, 4) clock cycles.
module uart_tx_oversampled #(
    parameter int unsigned DATA_WD     = 8,
    parameter int unsigned PRESCALE_WD = 6,
    parameter int unsigned BITCNT_WD   = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [PRESCALE_WD-1:0] prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [DATA_WD-1:0]     P_DATA,
    input  logic                   DATA_VALID,
    output logic                   TX_OUT,
    output logic                   Busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    localparam logic [PRESCALE_WD-1:0] MinPrescale = PRESCALE_WD'(4);
    localparam logic [BITCNT_WD-1:0]   LastBit     = BITCNT_WD'(DATA_WD - 1);

    state_t                 state_q, state_d;
    logic [PRESCALE_WD-1:0] tick_q, tick_d;
    logic [PRESCALE_WD-1:0] presc_q, presc_d;
    logic [BITCNT_WD-1:0]   bit_idx_q, bit_idx_d;
    logic [BITCNT_WD-1:0]   bit_idx_nxt;
    logic [DATA_WD-1:0]     data_q, data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   bit_end;

    assign bit_end     = (tick_q == presc_q - PRESCALE_WD'(1));
    assign bit_idx_nxt = bit_idx_q + BITCNT_WD'(1);
    assign TX_OUT      = tx_q;
    assign Busy        = busy_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            presc_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            presc_q   <= presc_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        presc_d   = presc_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        // Tick runs only inside a frame; it wraps at each bit end so it is 0 again in idle.
        if (state_q != StIdle) begin
            tick_d = bit_end ? '0 : tick_q + PRESCALE_WD'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    presc_d   = (prescale < MinPrescale) ? MinPrescale : prescale;
                    tick_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    tx_d      = data_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == LastBit) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_typ_q ? ~^data_q : ^data_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_nxt;
                        tx_d      = data_q[bit_idx_nxt];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
